// File: rtl/wait_state_mem.sv
// Word-addressed data memory with independent read and write engines, each
// answering after a fixed number of wait states.
module wait_state_mem #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDR_WIDTH    = 16,
  parameter int DEPTH_LOG2    = 10,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rready,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  we,
  output logic                  wack
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_WAIT = 2'd1;
  localparam logic [1:0] R_RESP = 2'd2;
  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_WAIT = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic [3:0] R_WAIT_CYCLES = 4'(READ_LATENCY - 1);
  localparam logic [3:0] W_WAIT_CYCLES = 4'(WRITE_LATENCY - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [1:0]            r_state_q, r_state_d;
  logic [3:0]            r_cnt_q, r_cnt_d;
  logic [DEPTH_LOG2-1:0] r_addr_q, r_addr_d;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  r_capture;

  logic [1:0]            w_state_q, w_state_d;
  logic [3:0]            w_cnt_q, w_cnt_d;
  logic [DEPTH_LOG2-1:0] w_addr_q, w_addr_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic                  w_commit;

  // Upper address bits only alias; fold them here so they are not dangling.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{raddr, waddr};

  always_comb begin
    r_state_d = r_state_q;
    r_cnt_d   = r_cnt_q;
    r_addr_d  = r_addr_q;
    case (r_state_q)
      R_IDLE: begin
        if (re) begin
          r_addr_d = raddr[DEPTH_LOG2-1:0];
          if (READ_LATENCY == 1) begin
            r_state_d = R_RESP;
          end else begin
            r_state_d = R_WAIT;
            r_cnt_d   = R_WAIT_CYCLES;
          end
        end
      end
      R_WAIT: begin
        r_cnt_d = r_cnt_q - 4'd1;
        if (r_cnt_q == 4'd1) r_state_d = R_RESP;
      end
      default: r_state_d = R_IDLE;
    endcase
    r_capture = (r_state_d == R_RESP);
  end

  always_comb begin
    w_state_d = w_state_q;
    w_cnt_d   = w_cnt_q;
    w_addr_d  = w_addr_q;
    w_data_d  = w_data_q;
    case (w_state_q)
      W_IDLE: begin
        if (we) begin
          w_addr_d = waddr[DEPTH_LOG2-1:0];
          w_data_d = wdata;
          if (WRITE_LATENCY == 1) begin
            w_state_d = W_RESP;
          end else begin
            w_state_d = W_WAIT;
            w_cnt_d   = W_WAIT_CYCLES;
          end
        end
      end
      W_WAIT: begin
        w_cnt_d = w_cnt_q - 4'd1;
        if (w_cnt_q == 4'd1) w_state_d = W_RESP;
      end
      default: w_state_d = W_IDLE;
    endcase
    w_commit = (w_state_d == W_RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      r_cnt_q   <= 4'd0;
      r_addr_q  <= '0;
      rdata_q   <= '0;
      w_state_q <= W_IDLE;
      w_cnt_q   <= 4'd0;
      w_addr_q  <= '0;
      w_data_q  <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_cnt_q   <= r_cnt_d;
      r_addr_q  <= r_addr_d;
      w_state_q <= w_state_d;
      w_cnt_q   <= w_cnt_d;
      w_addr_q  <= w_addr_d;
      w_data_q  <= w_data_d;
      // Reads the pre-write word when a commit hits the same index this edge.
      if (r_capture) rdata_q <= mem[r_addr_d];
    end
  end

  // The array is never reset; commits are suppressed while rst is held.
  always_ff @(posedge clk) begin
    if (w_commit && !rst) mem[w_addr_d] <= w_data_d;
  end

  assign rdata  = rdata_q;
  assign rready = (r_state_q == R_RESP);
  assign wack   = (w_state_q == W_RESP);

endmodule

// File: tb/tb_wait_state_mem.sv
// Bench for wait_state_mem: three instances with different latencies, checked
// against a word-array model and the request-to-response latency rules.
module tb_wait_state_mem;

  localparam int N_DUT = 3;

  function automatic int rlat(input int k);
    return (k == 0) ? 2 : (k == 1) ? 1 : 3;
  endfunction

  function automatic int wlat(input int k);
    return (k == 2) ? 4 : 1;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] raddr  [N_DUT];
  logic        re     [N_DUT];
  logic [15:0] rdata  [N_DUT];
  logic        rready [N_DUT];
  logic [15:0] waddr  [N_DUT];
  logic [15:0] wdata  [N_DUT];
  logic        we     [N_DUT];
  logic        wack   [N_DUT];

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] model_mem [N_DUT][1024];

  generate
    for (genvar gi = 0; gi < N_DUT; gi++) begin : g_dut
      wait_state_mem #(
        .DATA_WIDTH   (16),
        .ADDR_WIDTH   (16),
        .DEPTH_LOG2   (10),
        .READ_LATENCY (rlat(gi)),
        .WRITE_LATENCY(wlat(gi))
      ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .raddr (raddr[gi]),
        .re    (re[gi]),
        .rdata (rdata[gi]),
        .rready(rready[gi]),
        .waddr (waddr[gi]),
        .wdata (wdata[gi]),
        .we    (we[gi]),
        .wack  (wack[gi])
      );
    end
  endgenerate

  function automatic int widx(input logic [15:0] addr);
    return int'(addr) % 1024;
  endfunction

  // Raise re in an idle cycle, scramble raddr while waiting, expect the pulse
  // exactly rlat cycles later carrying the model word.
  task automatic do_read(input int k, input logic [15:0] addr);
    logic [15:0] exp_data;
    int lat;
    exp_data = model_mem[k][widx(addr)];
    lat = -1;
    raddr[k] = addr;
    re[k] = 1'b1;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(negedge clk);
      raddr[k] = 16'($urandom);
      if (rready[k] === 1'b1) lat = c;
    end
    re[k] = 1'b0;
    n_cmp++;
    if (lat != rlat(k)) begin
      n_bad++;
      $display("FAIL read_latency dut%0d addr %h: got %0d cycles, expected %0d", k, addr, lat, rlat(k));
    end
    if (lat > 0) begin
      n_cmp++;
      if (rdata[k] !== exp_data) begin
        n_bad++;
        $display("FAIL read_data dut%0d addr %h: got %h, expected %h", k, addr, rdata[k], exp_data);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (rready[k] !== 1'b0) begin
      n_bad++;
      $display("FAIL rready_width dut%0d: got %b, expected 0", k, rready[k]);
    end
    $display("read  dut%0d addr %h -> %h latency %0d", k, addr, rdata[k], lat);
  endtask

  task automatic do_write(input int k, input logic [15:0] addr, input logic [15:0] data);
    int lat;
    lat = -1;
    waddr[k] = addr;
    wdata[k] = data;
    we[k] = 1'b1;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(negedge clk);
      waddr[k] = 16'($urandom);
      wdata[k] = 16'($urandom);
      if (wack[k] === 1'b1) lat = c;
    end
    we[k] = 1'b0;
    if (lat > 0) model_mem[k][widx(addr)] = data;
    n_cmp++;
    if (lat != wlat(k)) begin
      n_bad++;
      $display("FAIL write_latency dut%0d addr %h: got %0d cycles, expected %0d", k, addr, lat, wlat(k));
    end
    @(negedge clk);
    n_cmp++;
    if (wack[k] !== 1'b0) begin
      n_bad++;
      $display("FAIL wack_width dut%0d: got %b, expected 0", k, wack[k]);
    end
    $display("write dut%0d addr %h <- %h latency %0d", k, addr, data, lat);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < N_DUT; k++) begin
      raddr[k] = '0; re[k] = 1'b0;
      waddr[k] = '0; wdata[k] = '0; we[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < N_DUT; k++) begin
      n_cmp++;
      if (rready[k] !== 1'b0 || wack[k] !== 1'b0 || rdata[k] !== 16'h0) begin
        n_bad++;
        $display("FAIL reset_outputs dut%0d: got rready=%b wack=%b rdata=%h, expected 0/0/0000",
                 k, rready[k], wack[k], rdata[k]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    $display("reset released");
  endtask

  task automatic test_preload();
    for (int k = 0; k < N_DUT; k++)
      for (int i = 0; i < 16; i++)
        do_write(k, 16'h0100 + 16'(i), 16'($urandom));
  endtask

  task automatic test_basic_read();
    do_write(0, 16'h0010, 16'hBEEF);
    do_read(0, 16'h0010);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (rdata[0] !== 16'hBEEF) begin
      n_bad++;
      $display("FAIL rdata_hold: got %h, expected beef", rdata[0]);
    end
  endtask

  task automatic test_write_readback();
    do_write(0, 16'h0020, 16'h1234);
    do_read(0, 16'h0020);
  endtask

  task automatic test_collision();
    logic [15:0] old_data;
    do_write(1, 16'h0030, 16'h1111);
    old_data = model_mem[1][widx(16'h0030)];
    raddr[1] = 16'h0030; re[1] = 1'b1;
    waddr[1] = 16'h0030; wdata[1] = 16'h2222; we[1] = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (rready[1] !== 1'b1 || wack[1] !== 1'b1 || rdata[1] !== old_data) begin
      n_bad++;
      $display("FAIL collision: got rready=%b wack=%b rdata=%h, expected 1/1/%h",
               rready[1], wack[1], rdata[1], old_data);
    end
    re[1] = 1'b0; we[1] = 1'b0;
    model_mem[1][widx(16'h0030)] = 16'h2222;
    @(negedge clk);
    n_cmp++;
    if (rready[1] !== 1'b0 || wack[1] !== 1'b0) begin
      n_bad++;
      $display("FAIL collision_pulse: got rready=%b wack=%b, expected 0/0", rready[1], wack[1]);
    end
    $display("collision dut1 addr 0030 old %h", old_data);
    do_read(1, 16'h0030);
  endtask

  // Held request: pulse every rlat+1 cycles, first one rlat cycles in.
  task automatic test_back_to_back();
    int pulses;
    logic exp_r;
    pulses = 0;
    raddr[2] = 16'h0105;
    re[2] = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      exp_r = ((c % (rlat(2) + 1)) == rlat(2));
      n_cmp++;
      if (rready[2] !== exp_r) begin
        n_bad++;
        $display("FAIL b2b_rready cycle %0d: got %b, expected %b", c, rready[2], exp_r);
      end
      if (exp_r) begin
        pulses++;
        n_cmp++;
        if (rdata[2] !== model_mem[2][widx(16'h0105)]) begin
          n_bad++;
          $display("FAIL b2b_rdata cycle %0d: got %h, expected %h", c, rdata[2], model_mem[2][widx(16'h0105)]);
        end
      end
    end
    re[2] = 1'b0;
    @(negedge clk);
    $display("back_to_back dut2 pulses %0d", pulses);
  endtask

  task automatic test_reset_mid_write();
    logic seen_wack;
    do_write(2, 16'h0042, 16'hA5A5);
    do_read(2, 16'h0042);
    waddr[2] = 16'h0042; wdata[2] = 16'h5A5A; we[2] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    we[2] = 1'b0;
    #1;
    for (int k = 0; k < N_DUT; k++) begin
      n_cmp++;
      if (rready[k] !== 1'b0 || wack[k] !== 1'b0 || rdata[k] !== 16'h0) begin
        n_bad++;
        $display("FAIL async_reset dut%0d: got rready=%b wack=%b rdata=%h, expected 0/0/0000",
                 k, rready[k], wack[k], rdata[k]);
      end
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen_wack = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (wack[2] !== 1'b0) seen_wack = 1'b1;
    end
    n_cmp++;
    if (seen_wack) begin
      n_bad++;
      $display("FAIL wack_after_reset: got 1, expected 0");
    end
    $display("reset during write wait dut2");
    do_read(2, 16'h0042);
  endtask

  task automatic test_aliasing();
    do_read(0, 16'h0410);
    do_write(0, 16'hFC20, 16'h7777);
    do_read(0, 16'h0020);
  endtask

  task automatic test_random();
    logic [15:0] addr;
    for (int k = 0; k < N_DUT; k++) begin
      for (int n = 0; n < 25; n++) begin
        addr = (16'($urandom) & 16'hFC00) | (16'h0100 + 16'($urandom_range(0, 15)));
        if ($urandom_range(0, 1) == 0) do_write(k, addr, 16'($urandom));
        else do_read(k, addr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_basic_read();
    test_write_readback();
    test_collision();
    test_back_to_back();
    test_reset_mid_write();
    test_aliasing();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
